// File: rtl/fp_add_pkg.sv
// Shared constants, state/class encodings and helpers for the sequential
// binary64 adder.
package fp_add_pkg;
    localparam int EXP_W   = 11;
    localparam int FRAC_W  = 52;
    localparam int BIAS    = 1023;
    localparam int MAN_W   = FRAC_W + 1;
    localparam int WRK_W   = MAN_W + 3;
    localparam int SH_MAX  = FRAC_W + 3;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {IDLE, UNP, ALN, ADD, NRM, RND, DONE} state_t;
    typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_QNAN, C_SNAN} cls_t;

    function automatic cls_t classify(input logic [63:0] v);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        cls_t              c;
        e = v[FRAC_W+EXP_W-1:FRAC_W];
        f = v[FRAC_W-1:0];
        if (e == {EXP_W{1'b1}}) begin
            if (f == {FRAC_W{1'b0}}) c = C_INF;
            else if (f[FRAC_W-1])    c = C_QNAN;
            else                     c = C_SNAN;
        end else if (e == {EXP_W{1'b0}}) begin
            c = (f == {FRAC_W{1'b0}}) ? C_ZERO : C_SUB;
        end else begin
            c = C_NORM;
        end
        return c;
    endfunction

    // Leading zeros of the working significand; all-zero returns WRK_W.
    function automatic logic [5:0] lzc(input logic [WRK_W-1:0] v);
        logic [5:0] n;
        n = 6'(WRK_W);
        for (int i = 0; i < WRK_W; i++) begin
            if (v[i]) n = 6'(WRK_W - 1 - i);
        end
        return n;
    endfunction
endpackage

// File: rtl/fp_add_seq_special_chk.sv
// Operand classifier and special-case (NaN / infinity) result policy.
module fp_special_chk
    import fp_add_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        eop,
    output cls_t        cls_a,
    output cls_t        cls_b,
    output logic        spc_valid,
    output logic [63:0] spc_result,
    output logic        inf_flag,
    output logic        nan_flag,
    output logic        inv_flag
);
    logic any_nan_s, any_snan_s;

    // b's effective sign equals sign(a)^eop, so an infinite b needs no sub input.
    always_comb begin
        cls_a      = classify(a);
        cls_b      = classify(b);
        any_nan_s  = (cls_a == C_QNAN) || (cls_a == C_SNAN) ||
                     (cls_b == C_QNAN) || (cls_b == C_SNAN);
        any_snan_s = (cls_a == C_SNAN) || (cls_b == C_SNAN);
        spc_valid  = 1'b1;
        spc_result = QNAN;
        inf_flag   = 1'b0;
        nan_flag   = 1'b0;
        inv_flag   = 1'b0;
        if (any_nan_s) begin
            nan_flag = 1'b1;
            inv_flag = any_snan_s;
        end else if ((cls_a == C_INF) && (cls_b == C_INF) && eop) begin
            inv_flag = 1'b1;
        end else if (cls_a == C_INF) begin
            spc_result = {a[63], {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            inf_flag   = 1'b1;
        end else if (cls_b == C_INF) begin
            spc_result = {a[63] ^ eop, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            inf_flag   = 1'b1;
        end else begin
            spc_valid = 1'b0;
        end
    end
endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 binary64 add/subtract sequencer with valid/ready
// handshakes on both sides and an early exit for NaN/infinity operands.
module fp_add_seq
    import fp_add_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        inf_flag,
    output logic        nan_flag,
    output logic        inv_flag,
    output logic        ovf_flag,
    output logic        busy
);
    state_t              state_r, state_nxt_s;
    logic [63:0]         a_r, b_r;
    logic                sub_r, sign_r, eop_r;
    logic [EXP_W:0]      exp_r, d_r;
    logic [MAN_W-1:0]    x_man_r, y_man_r;
    logic [WRK_W-1:0]    y_wrk_r, nrm_r;
    logic [WRK_W:0]      sum_r;

    cls_t                cls_a_s, cls_b_s;
    logic                spc_valid_s, spc_inf_s, spc_nan_s, spc_inv_s;
    logic [63:0]         spc_result_s;
    logic                eop_s, swap_s, x_sign_s, hid_x_s, hid_y_s;
    logic [63:0]         x_op_s, y_op_s;
    logic [EXP_W:0]      ex_s, ey_s;
    logic [5:0]          aln_sh_s, lz_s;
    logic [2*WRK_W-1:0]  aln_wide_s;
    logic [WRK_W-1:0]    aln_y_s, nrm_man_s;
    logic [WRK_W:0]      sum_s;
    logic [EXP_W:0]      lim_s, nsh_s, nrm_exp_s, rnd_exp_s;
    logic                rnd_up_s;
    logic [MAN_W:0]      rnd_m_s;
    logic [FRAC_W-1:0]   rnd_frac_s;

    assign eop_s = a_r[63] ^ b_r[63] ^ sub_r;

    fp_special_chk u_chk (
        .a          (a_r),
        .b          (b_r),
        .eop        (eop_s),
        .cls_a      (cls_a_s),
        .cls_b      (cls_b_s),
        .spc_valid  (spc_valid_s),
        .spc_result (spc_result_s),
        .inf_flag   (spc_inf_s),
        .nan_flag   (spc_nan_s),
        .inv_flag   (spc_inv_s)
    );

    // Unpack and swap so X holds the larger magnitude; subnormals use exponent 1.
    always_comb begin
        swap_s   = b_r[62:0] > a_r[62:0];
        x_op_s   = swap_s ? b_r : a_r;
        y_op_s   = swap_s ? a_r : b_r;
        x_sign_s = swap_s ? (b_r[63] ^ sub_r) : a_r[63];
        hid_x_s  = swap_s ? (cls_b_s == C_NORM) : (cls_a_s == C_NORM);
        hid_y_s  = swap_s ? (cls_a_s == C_NORM) : (cls_b_s == C_NORM);
        ex_s     = hid_x_s ? {1'b0, x_op_s[62:FRAC_W]} : {{EXP_W{1'b0}}, 1'b1};
        ey_s     = hid_y_s ? {1'b0, y_op_s[62:FRAC_W]} : {{EXP_W{1'b0}}, 1'b1};
    end

    // Alignment shift with sticky collection, then the significand add/subtract.
    always_comb begin
        aln_sh_s   = (d_r > (EXP_W+1)'(SH_MAX)) ? 6'(SH_MAX) : d_r[5:0];
        aln_wide_s = {y_man_r, 3'b000, {WRK_W{1'b0}}} >> aln_sh_s;
        aln_y_s    = {aln_wide_s[2*WRK_W-1:WRK_W+1],
                      aln_wide_s[WRK_W] | (|aln_wide_s[WRK_W-1:0])};
        if (eop_r) sum_s = {1'b0, x_man_r, 3'b000} - {1'b0, y_wrk_r};
        else       sum_s = {1'b0, x_man_r, 3'b000} + {1'b0, y_wrk_r};
    end

    // Normalize: right by one on carry, else left by lzc clamped at exponent 1.
    always_comb begin
        lz_s  = lzc(sum_r[WRK_W-1:0]);
        lim_s = exp_r - {{EXP_W{1'b0}}, 1'b1};
        nsh_s = ({6'd0, lz_s} > lim_s) ? lim_s : {6'd0, lz_s};
        if (sum_r[WRK_W]) begin
            nrm_man_s = {sum_r[WRK_W:2], |sum_r[1:0]};
            nrm_exp_s = exp_r + {{EXP_W{1'b0}}, 1'b1};
        end else begin
            nrm_man_s = sum_r[WRK_W-1:0] << nsh_s;
            nrm_exp_s = exp_r - nsh_s;
        end
    end

    // Round to nearest even; a missing hidden bit after rounding encodes exponent 0.
    always_comb begin
        rnd_up_s = nrm_r[2] & (nrm_r[1] | nrm_r[0] | nrm_r[3]);
        rnd_m_s  = {1'b0, nrm_r[WRK_W-1:3]} + {{MAN_W{1'b0}}, rnd_up_s};
        if (rnd_m_s[MAN_W]) begin
            rnd_exp_s  = exp_r + {{EXP_W{1'b0}}, 1'b1};
            rnd_frac_s = rnd_m_s[FRAC_W:1];
        end else begin
            rnd_exp_s  = rnd_m_s[FRAC_W] ? exp_r : {(EXP_W+1){1'b0}};
            rnd_frac_s = rnd_m_s[FRAC_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = in_valid ? UNP : IDLE;
            UNP:     state_nxt_s = spc_valid_s ? DONE : ALN;
            ALN:     state_nxt_s = ADD;
            ADD:     state_nxt_s = NRM;
            NRM:     state_nxt_s = RND;
            RND:     state_nxt_s = DONE;
            DONE:    state_nxt_s = out_ready ? IDLE : DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_r)
            IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
            DONE:    out_valid = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Datapath registers, result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= 64'd0; b_r <= 64'd0; sub_r <= 1'b0;
            sign_r <= 1'b0; eop_r <= 1'b0;
            exp_r <= '0; d_r <= '0; x_man_r <= '0; y_man_r <= '0;
            y_wrk_r <= '0; nrm_r <= '0; sum_r <= '0;
            result <= 64'd0;
            inf_flag <= 1'b0; nan_flag <= 1'b0; inv_flag <= 1'b0; ovf_flag <= 1'b0;
        end else begin
            case (state_r)
                IDLE: if (in_valid) begin
                    a_r <= a; b_r <= b; sub_r <= sub;
                    inf_flag <= 1'b0; nan_flag <= 1'b0; inv_flag <= 1'b0; ovf_flag <= 1'b0;
                end
                UNP: begin
                    sign_r  <= x_sign_s;
                    eop_r   <= eop_s;
                    exp_r   <= ex_s;
                    d_r     <= ex_s - ey_s;
                    x_man_r <= {hid_x_s, x_op_s[FRAC_W-1:0]};
                    y_man_r <= {hid_y_s, y_op_s[FRAC_W-1:0]};
                    if (spc_valid_s) begin
                        result   <= spc_result_s;
                        inf_flag <= spc_inf_s;
                        nan_flag <= spc_nan_s;
                        inv_flag <= spc_inv_s;
                    end
                end
                ALN: y_wrk_r <= aln_y_s;
                ADD: begin
                    sum_r <= sum_s;
                    // Exact cancellation gives +0; like-signed zeros keep their sign.
                    if (sum_s == '0 && eop_r) sign_r <= 1'b0;
                end
                NRM: begin
                    nrm_r <= nrm_man_s;
                    exp_r <= nrm_exp_s;
                end
                RND: begin
                    if (rnd_exp_s >= (EXP_W+1)'(EXP_MAX)) begin
                        result   <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                        ovf_flag <= 1'b1;
                    end else begin
                        result <= {sign_r, rnd_exp_s[EXP_W-1:0], rnd_frac_s};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq: expectations queued at drive time,
// compared when out_valid appears.
module tb_fp_add_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, out_valid, out_ready, busy;
    logic        inf_flag, nan_flag, inv_flag, ovf_flag;
    logic [63:0] a, b, result;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fp_add_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .inf_flag(inf_flag), .nan_flag(nan_flag),
        .inv_flag(inv_flag), .ovf_flag(ovf_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Present one pair; returns just after the accepting edge with inputs scrambled.
    task automatic drive(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                         input logic ts, input logic [63:0] er, input logic [3:0] ef,
                         input int el);
        exp_t e;
        @(negedge clk);
        check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        e.tag = tag; e.res = er; e.flg = ef; e.lat = el;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        sub = ~ts;
    endtask

    // Accepting edge counts as edge 1; out_valid is expected after edge `lat`.
    task automatic collect(input int stall);
        exp_t e;
        int   lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sbq.pop_front();
        check({e.tag, ".out_valid"}, {63'd0, out_valid}, 64'd1);
        check({e.tag, ".latency"}, 64'(lat), 64'(e.lat));
        check({e.tag, ".result"}, result, e.res);
        check({e.tag, ".flags"}, {60'd0, inf_flag, nan_flag, inv_flag, ovf_flag}, {60'd0, e.flg});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({e.tag, ".held_result"}, result, e.res);
            check({e.tag, ".held_flags"}, {60'd0, inf_flag, nan_flag, inv_flag, ovf_flag}, {60'd0, e.flg});
            check({e.tag, ".held_in_ready"}, {62'd0, in_ready, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({e.tag, ".back_to_idle"}, {61'd0, in_ready, out_valid, busy}, 64'd4);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = 64'd0; b = 64'd0; sub = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("reset.ctl", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check("reset.result", result, 64'd0);
        check("reset.flags", {60'd0, inf_flag, nan_flag, inv_flag, ovf_flag}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // flags below are {inf, nan, inv, ovf}
        drive("one_plus_two", 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 4'b0000, 6);
        collect(0);
        drive("inf_minus_inf", 64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, 64'h7FF8000000000000, 4'b0010, 2);
        collect(0);
        drive("inf_plus_inf", 64'h7FF0000000000000, 64'h7FF0000000000000, 1'b0, 64'h7FF0000000000000, 4'b1000, 2);
        collect(0);
        drive("one_minus_inf", 64'h3FF0000000000000, 64'h7FF0000000000000, 1'b1, 64'hFFF0000000000000, 4'b1000, 2);
        collect(0);
        drive("cancel", 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h0000000000000000, 4'b0000, 6);
        collect(0);
        drive("cancel_add", 64'h3FF0000000000000, 64'hBFF0000000000000, 1'b0, 64'h0000000000000000, 4'b0000, 6);
        collect(0);
        drive("neg_zeros", 64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h8000000000000000, 4'b0000, 6);
        collect(0);
        drive("tie_even", 64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 4'b0000, 6);
        collect(0);
        drive("two_minus_one", 64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000, 4'b0000, 6);
        collect(0);
        drive("subnormals", 64'h0000000000000001, 64'h0000000000000001, 1'b0, 64'h0000000000000002, 4'b0000, 6);
        collect(0);
        drive("overflow", 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 4'b0001, 6);
        collect(0);
        drive("snan", 64'h7FF4000000000000, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000, 4'b0110, 2);
        collect(0);
        drive("qnan", 64'h3FF0000000000000, 64'hFFF8000000000001, 1'b1, 64'h7FF8000000000000, 4'b0100, 2);
        collect(0);

        drive("backpressure", 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 4'b0000, 6);
        collect(4);
        drive("after_bp", 64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000, 4'b0000, 6);
        collect(0);

        // Abort while in ALN (one edge after the accepting edge).
        drive("aborted", 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 4'b0000, 6);
        sbq.delete(0);
        @(posedge clk);
        #1;
        check("abort.busy_in_aln", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort.ctl", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check("abort.result", result, 64'd0);
        drive("after_abort", 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 4'b0000, 6);
        collect(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_add_seq.md
Name: fp_add_seq

Overview:
- Multi-cycle sequencer and controller for the IEEE-754 double-precision adder.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Runs the special-case check (infinity, NaN, invalid) first and exits early with the result when a case is found.
- Otherwise steps the operands through align, add, normalize and round states, and returns the result with status flags through an output valid/ready handshake. It sits between the FPU issue logic and the writeback.

Parameters:
EXP_W, 11, exponent field width
FRAC_W, 52, stored fraction width (significand is FRAC_W+1 bits including the hidden bit)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  high only in IDLE
a  input  64  operand A, IEEE binary64
b  input  64  operand B, IEEE binary64
sub  input  1  1 = compute a-b, 0 = compute a+b
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts the result
result  output  64  IEEE binary64 result
inf_flag  output  1  result is infinite because an operand was infinite
nan_flag  output  1  at least one operand is NaN
inv_flag  output  1  invalid operation: inf-inf under effective subtraction, or any sNaN input
ovf_flag  output  1  finite operands rounded to overflow (result is ±inf)
busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all flags=0. A reset in any state aborts the operation. On the cycle after the reset edge these values hold and the partial operation is discarded.
- Accept: an operand pair is latched when in_valid & in_ready are high at a rising edge. a, b and sub are registered, and later changes on those inputs are ignored. The next state is UNP. At most one operation is in flight.
- Effective subtraction: eop = sign(a) ^ sign(b) ^ sub.
- UNP (1 cycle):
  - Classify both operands as zero, subnormal, normal, inf, qNaN or sNaN.
  - Swap so |X| >= |Y|.
  - Compute d = expX - expY. Subnormals use exponent 1 and hidden bit 0.
  - If a special case applies, go to DONE. Otherwise go to ALN.
- Special cases, in priority order:
  1. Any NaN: result=7FF8000000000000, nan_flag=1; inv_flag=1 if any operand is an sNaN.
  2. inf with inf and eop=1: result=7FF8000000000000, inv_flag=1.
  3. Any inf: result=that infinity with its effective sign, inf_flag=1.
- ALN: right-shift the Y significand by min(d, FRAC_W+3), keeping guard, round and sticky bits. Sticky is the OR of all bits shifted out.
- ADD: if eop=0, compute X+Y; otherwise compute X-Y. The result sign is the sign of X. An exact zero result takes +0, except that -0 + -0 gives -0.
- NRM:
  - On carry-out, shift right by 1 and increment the exponent.
  - Otherwise left-shift by the leading-zero count, limited so the exponent does not drop below 1.
  - If the hidden bit is still 0 at exponent 1, encode biased exponent 0 (subnormal or zero).
- RND:
  - Round to nearest, ties to even, using guard/round/sticky.
  - A rounding carry renormalizes and increments the exponent.
  - If the exponent reaches 2^EXP_W-1, the result is ±inf and ovf_flag=1.
- Latency:
  - Normal path: out_valid rises after the 6th rising edge following the accepting edge (UNP, ALN, ADD, NRM, RND, DONE).
  - Special path: out_valid rises after the 2nd edge (UNP, DONE).
- DONE:
  - out_valid=1. result and the flags are stable until out_valid & out_ready at a rising edge; the next state is then IDLE.
  - out_ready=0 stalls indefinitely with all outputs held.
  - No new input is accepted in DONE. The minimum initiation interval is 7 cycles on the normal path and 3 cycles on the special path.
- Flags are cleared on accept and are valid only while out_valid=1.

Decomposition:
- Package fp_add_pkg holds:
  - EXP_W, FRAC_W and BIAS.
  - QNAN constant 7FF8000000000000.
  - The state enum {IDLE, UNP, ALN, ADD, NRM, RND, DONE}.
  - The operand class enum {ZERO, SUB, NORM, INF, QNAN, SNAN}.
- Sub-module fp_special_chk: a combinational classifier. Inputs are the two registered operands and eop. Outputs are both class codes plus the special-case valid, special result and inf/nan/inv flags. It keeps the special-case policy separate from the sequencing FSM.

Test Plan:
1. a=3FF0000000000000, b=4000000000000000, sub=0 -> result=4008000000000000, all flags 0, out_valid after the 6th edge.
2. a=7FF0000000000000, b=7FF0000000000000, sub=1 -> result=7FF8000000000000, inv_flag=1, inf_flag=0, out_valid after the 2nd edge. Same operands with sub=0 -> result=7FF0000000000000, inf_flag=1.
3. Cancellation and rounding, each with flags 0:
   - a=3FF0000000000000, b=3FF0000000000000, sub=1 -> result=0000000000000000 (+0).
   - a=3FF0000000000000, b=3CA0000000000000 (2^-53), sub=0 -> result=3FF0000000000000 (tie, rounds to even).
4. a=b=7FEFFFFFFFFFFFFF, sub=0 -> result=7FF0000000000000, ovf_flag=1. a=7FF4000000000000 (sNaN) plus any b -> QNAN, nan_flag=1, inv_flag=1.
5. Backpressure: case 1 with out_ready=0 for 4 cycles after out_valid -> result and flags held, in_ready=0. Raise out_ready -> IDLE and in_ready=1 on the next cycle, then accept a second pair.
6. Reset mid-operation: assert rst for 1 cycle while in ALN -> next cycle state=IDLE, out_valid=0, result=0, in_ready=1. A new operation then completes correctly.
